// File: rtl/noc_bridge_vc_rx_credit_return.sv
// NoC bridge Rx: per-VC flit FIFOs and credit-return offers to the local Tx.
// Optional idle-timeout offers are enabled by NOC_BRIDGE_RX_CRED_TIMEOUT_EN.
module noc_bridge_vc_rx_credit_return #(
    parameter int unsigned DataWidth       = 64,
    parameter int unsigned NumCred         = 8,
    parameter int unsigned ForceSendThresh = NumCred - 4,
    parameter int unsigned CredWidth       = $clog2(NumCred + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 axis_in_tvalid_i,
    output logic                 axis_in_tready_o,
    input  logic [DataWidth:0]   axis_in_tdata_i,
    input  logic [CredWidth+1:0] axis_in_tuser_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [DataWidth-1:0] req_data_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DataWidth-1:0] rsp_data_o,
    output logic                 rx_cred_valid_o,
    output logic                 rx_cred_hdr_o,
    output logic [CredWidth-1:0] rx_cred_o,
    output logic                 cred_ret_valid_o,
    input  logic                 cred_ret_ready_i,
    output logic                 cred_ret_hdr_o,
    output logic [CredWidth-1:0] cred_ret_o
);

    localparam int unsigned PtrW = (NumCred > 1) ? $clog2(NumCred) : 1;
    localparam logic [CredWidth-1:0] Thresh = CredWidth'(ForceSendThresh);
    localparam logic [CredWidth-1:0] Depth  = CredWidth'(NumCred);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    logic                           in_dval;
    logic                           in_dhdr;
    logic                           in_chdr;
    logic [CredWidth-1:0]           in_cred;
    logic                           accept;
    logic [1:0]                     full;
    logic [1:0]                     empty;
    logic [1:0]                     push;
    logic [1:0]                     pop;
    logic [1:0]                     out_ready;
    logic [1:0][DataWidth-1:0]      head;
    logic [1:0][CredWidth-1:0]      pend_q;
    logic [1:0][CredWidth-1:0]      pend_d;
    state_e                         state_q;
    state_e                         state_d;
    logic                           cred_hdr_q;
    logic                           cred_hdr_d;
    logic [CredWidth-1:0]           cred_ret_q;
    logic [CredWidth-1:0]           cred_ret_d;
    logic                           rx_valid_q;
    logic                           rx_hdr_q;
    logic [CredWidth-1:0]           rx_cred_q;
    logic                           trigger;
    logic                           timeout;
    logic                           sel;

    assign in_dval   = axis_in_tuser_i[CredWidth+1];
    assign in_chdr   = axis_in_tuser_i[CredWidth];
    assign in_cred   = axis_in_tuser_i[CredWidth-1:0];
    assign in_dhdr   = axis_in_tdata_i[DataWidth];
    assign out_ready = {rsp_ready_i, req_ready_i};

    // Credit-only packets never touch a FIFO, so they are always taken.
    assign axis_in_tready_o = ~in_dval | ~full[in_dhdr];
    assign accept           = axis_in_tvalid_i & axis_in_tready_o;

    for (genvar v = 0; v < 2; v++) begin : g_vc
        logic [DataWidth-1:0] mem_q [NumCred];
        logic [PtrW-1:0]      wptr_q;
        logic [PtrW-1:0]      rptr_q;
        logic [CredWidth-1:0] cnt_q;

        assign full[v]  = (cnt_q == Depth);
        assign empty[v] = (cnt_q == '0);
        assign push[v]  = accept & in_dval & (in_dhdr == 1'(v));
        assign pop[v]   = ~empty[v] & out_ready[v];
        assign head[v]  = empty[v] ? '0 : mem_q[rptr_q];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[v]) begin
                    wptr_q <= (wptr_q == PtrW'(NumCred - 1)) ? '0 : wptr_q + PtrW'(1);
                end
                if (pop[v]) begin
                    rptr_q <= (rptr_q == PtrW'(NumCred - 1)) ? '0 : rptr_q + PtrW'(1);
                end
                cnt_q <= cnt_q + CredWidth'(push[v]) - CredWidth'(pop[v]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[v]) begin
                mem_q[wptr_q] <= axis_in_tdata_i[DataWidth-1:0];
            end
        end

`ifndef SYNTHESIS
        a_budget: assert property (@(posedge clk_i) disable iff (!rst_ni)
            ({1'b0, pend_q[v]} + {1'b0, cnt_q}) <= {1'b0, Depth});
`endif
    end

    assign req_valid_o = ~empty[0];
    assign req_data_o  = head[0];
    assign rsp_valid_o = ~empty[1];
    assign rsp_data_o  = head[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_valid_q <= 1'b0;
            rx_hdr_q   <= 1'b0;
            rx_cred_q  <= '0;
        end else begin
            rx_valid_q <= accept;
            if (accept) begin
                rx_hdr_q  <= in_chdr;
                rx_cred_q <= in_cred;
            end
        end
    end

    assign rx_cred_valid_o = rx_valid_q;
    assign rx_cred_hdr_o   = rx_hdr_q;
    assign rx_cred_o       = rx_cred_q;

`ifdef NOC_BRIDGE_RX_CRED_TIMEOUT_EN
    logic [4:0] tmr_q;
    logic [4:0] tmr_d;

    assign timeout = tmr_q[4] & ((|pend_q[0]) | (|pend_q[1]));

    always_comb begin
        tmr_d = tmr_q;
        if ((state_q == IDLE) && trigger) begin
            tmr_d = '0;
        end else if (!tmr_q[4]) begin
            tmr_d = tmr_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Ties go to the response VC.
    assign sel     = (pend_q[1] >= pend_q[0]);
    assign trigger = (pend_q[0] >= Thresh) | (pend_q[1] >= Thresh) | timeout;

    always_comb begin
        state_d    = state_q;
        cred_ret_d = cred_ret_q;
        cred_hdr_d = cred_hdr_q;
        pend_d[0]  = pend_q[0] + CredWidth'(pop[0]);
        pend_d[1]  = pend_q[1] + CredWidth'(pop[1]);
        unique case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d      = OFFER;
                    cred_hdr_d   = sel;
                    cred_ret_d   = pend_q[sel];
                    pend_d[sel]  = CredWidth'(pop[sel]);
                end
            end
            OFFER: begin
                if (cred_ret_ready_i) begin
                    state_d    = IDLE;
                    cred_ret_d = '0;
                    cred_hdr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            cred_ret_q <= '0;
            cred_hdr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            cred_ret_q <= cred_ret_d;
            cred_hdr_q <= cred_hdr_d;
        end
    end

    assign cred_ret_valid_o = (state_q == OFFER);
    assign cred_ret_hdr_o   = cred_hdr_q;
    assign cred_ret_o       = cred_ret_q;

endmodule

// File: tb/tb_noc_bridge_vc_rx_credit_return.sv
// Directed bench for noc_bridge_vc_rx_credit_return with a flit/credit scoreboard.
// Offer timing under NOC_BRIDGE_RX_CRED_TIMEOUT_EN is checked when the macro is set.
module tb_noc_bridge_vc_rx_credit_return;

    localparam int DW = 64;
    localparam int NC = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [DW:0]   tdata = '0;
    logic [CW+1:0] tuser = '0;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rx_valid;
    logic          rx_hdr;
    logic [CW-1:0] rx_cred;
    logic          cret_valid;
    logic          cret_ready = 1'b0;
    logic          cret_hdr;
    logic [CW-1:0] cret;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] req_q[$];
    logic [DW-1:0] rsp_q[$];
    logic [CW:0]   rxc_q[$];

    always #5 clk = ~clk;

    noc_bridge_vc_rx_credit_return #(
        .DataWidth(DW),
        .NumCred(NC),
        .ForceSendThresh(NC - 4),
        .CredWidth(CW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .axis_in_tvalid_i(tvalid),
        .axis_in_tready_o(tready),
        .axis_in_tdata_i(tdata),
        .axis_in_tuser_i(tuser),
        .req_valid_o(req_valid),
        .req_ready_i(req_ready),
        .req_data_o(req_data),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data),
        .rx_cred_valid_o(rx_valid),
        .rx_cred_hdr_o(rx_hdr),
        .rx_cred_o(rx_cred),
        .cred_ret_valid_o(cret_valid),
        .cred_ret_ready_i(cret_ready),
        .cred_ret_hdr_o(cret_hdr),
        .cred_ret_o(cret)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        tvalid     = 1'b0;
        tuser      = '0;
        req_ready  = 1'b0;
        rsp_ready  = 1'b0;
        cret_ready = 1'b0;
        req_q.delete();
        rsp_q.delete();
        rxc_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic dhdr, input logic dval, input logic chdr,
                        input logic [CW-1:0] cr);
        logic [DW-1:0] d;
        bit ok;
        ok     = 1'b0;
        d      = {$urandom, $urandom};
        tvalid = 1'b1;
        tdata  = {dhdr, d};
        tuser  = {dval, chdr, cr};
        for (int i = 0; i < 50; i++) begin
            #1;
            if (tready) begin
                ok = 1'b1;
                rxc_q.push_back({chdr, cr});
                if (dval) begin
                    if (dhdr) rsp_q.push_back(d);
                    else      req_q.push_back(d);
                end
                break;
            end
            tick();
        end
        check("send_accept", ok, 1);
        tick();
        tvalid = 1'b0;
        tuser  = '0;
    endtask

    task automatic wait_offer(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (cret_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                if (req_q.size() == 0) check("req_unexpected", 1, 0);
                else check("req_data", req_data, req_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_data", rsp_data, rsp_q.pop_front());
            end
            if (rx_valid) begin
                if (rxc_q.size() == 0) check("rx_cred_unexpected", 1, 0);
                else check("rx_cred", {rx_hdr, rx_cred}, rxc_q.pop_front());
            end
        end
    end

    initial begin
        bit found;
        int seen;
        int bad;

        // reset values
        repeat (2) tick();
        check("rst_tready", tready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_cret_valid", cret_valid, 0);
        check("rst_cret", cret, 0);
        check("rst_req_data", req_data, 0);
        rst_n = 1'b1;
        tick();

        // three request flits, no offer
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) send(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) tick();
        check("s1_req_drained", req_q.size(), 0);
        check("s1_pend_req", dut.pend_q[0], 3);
        seen = 0;
        repeat (4) begin
            if (cret_valid) seen++;
            tick();
        end
        check("s1_no_offer", seen, 0);

        // four request flits, offer held under back-pressure
        do_reset();
        req_ready = 1'b1;
        repeat (4) send(1'b0, 1'b1, 1'b0, 4'd0);
        wait_offer(20, found);
        check("s2_offer_seen", found, 1);
        check("s2_hdr", cret_hdr, 0);
        check("s2_cred", cret, 4);
        bad = 0;
        repeat (5) begin
            tick();
            if (!(cret_valid && cret == 4'd4 && cret_hdr == 1'b0)) bad++;
        end
        check("s2_stable", bad, 0);
        cret_ready = 1'b1;
        tick();
        cret_ready = 1'b0;
        check("s2_valid_drop", cret_valid, 0);
        check("s2_pend_req", dut.pend_q[0], 0);

        // tie between VCs: response first, then request after one idle cycle
        do_reset();
        repeat (4) send(1'b0, 1'b1, 1'b0, 4'd0);
        repeat (4) send(1'b1, 1'b1, 1'b0, 4'd0);
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        wait_offer(20, found);
        check("s3_offer_seen", found, 1);
        check("s3_hdr_first", cret_hdr, 1);
        check("s3_cred_first", cret, 4);
        cret_ready = 1'b1;
        tick();
        cret_ready = 1'b0;
        check("s3_gap", cret_valid, 0);
        tick();
        check("s3_second_valid", cret_valid, 1);
        check("s3_hdr_second", cret_hdr, 0);
        check("s3_cred_second", cret, 4);
        cret_ready = 1'b1;
        tick();
        cret_ready = 1'b0;

        // full request FIFO, then a credit-only packet
        do_reset();
        cret_ready = 1'b1;
        repeat (8) send(1'b0, 1'b1, 1'b0, 4'd0);
        tvalid = 1'b1;
        tdata  = '0;
        tuser  = {1'b1, 1'b0, 4'd0};
        #1;
        check("s4_full_tready", tready, 0);
        tvalid = 1'b0;
        tuser  = '0;
        send(1'b0, 1'b0, 1'b1, 4'd3);
        check("s4_rx_valid", rx_valid, 1);
        check("s4_rx_cred", {rx_hdr, rx_cred}, {1'b1, 4'd3});
        req_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (req_q.size() == 0) break;
            tick();
        end
        check("s4_req_drained", req_q.size(), 0);
        repeat (4) tick();
        cret_ready = 1'b0;

        // drain coincides with the offer cycle
        do_reset();
        repeat (5) send(1'b1, 1'b1, 1'b0, 4'd0);
        rsp_ready = 1'b1;
        wait_offer(20, found);
        check("s5_offer_seen", found, 1);
        check("s5_hdr", cret_hdr, 1);
        check("s5_cred", cret, 4);
        check("s5_pend_rsp", dut.pend_q[1], 1);
        cret_ready = 1'b1;
        tick();
        cret_ready = 1'b0;

        // single pending credit with no further traffic
        do_reset();
        req_ready = 1'b1;
        send(1'b0, 1'b1, 1'b0, 4'd0);
`ifdef NOC_BRIDGE_RX_CRED_TIMEOUT_EN
        wait_offer(40, found);
        check("s6_timeout_offer", found, 1);
        check("s6_hdr", cret_hdr, 0);
        check("s6_cred", cret, 1);
        cret_ready = 1'b1;
        tick();
        cret_ready = 1'b0;
`else
        seen = 0;
        repeat (100) begin
            if (cret_valid) seen++;
            tick();
        end
        check("s6_no_offer", seen, 0);
        check("s6_pend_req", dut.pend_q[0], 1);
`endif

        // reset in the middle of an offer discards it
        do_reset();
        req_ready = 1'b1;
        repeat (4) send(1'b0, 1'b1, 1'b0, 4'd0);
        wait_offer(20, found);
        check("s7_offer_seen", found, 1);
        rst_n = 1'b0;
        #1;
        check("s7_async_valid", cret_valid, 0);
        check("s7_async_cred", cret, 0);
        check("s7_async_hdr", cret_hdr, 0);
        tick();
        rst_n = 1'b1;
        tick();
        seen = 0;
        repeat (20) begin
            if (cret_valid) seen++;
            tick();
        end
        check("s7_no_offer", seen, 0);
        check("s7_pend_req", dut.pend_q[0], 0);
        check("end_rx_queue", rxc_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noc_bridge_vc_rx_credit_return.md
NOC_BRIDGE_VC_RX_CREDIT_RETURN -- requirements
Module: noc_bridge_vc_rx_credit_return

Interface
REQ-001 Parameter DataWidth, default 64: NoC flit payload width in bits, header bit excluded.
REQ-002 Parameter NumCred, default 8: depth of each per-VC receive FIFO and the credit budget granted to the remote sender.
REQ-003 Parameter ForceSendThresh, default NumCred-4: pending-credit level that triggers a credit-return offer.
REQ-004 Parameter CredWidth, default $clog2(NumCred+1): credit count width.
REQ-005 clk_i  in  1  single clock; all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 axis_in_tvalid_i / axis_in_tready_o  in/out  1  incoming AXIS handshake.
REQ-008 axis_in_tdata_i  in  DataWidth+1  {data_hdr (0=request, 1=response), flit data}.
REQ-009 axis_in_tuser_i  in  CredWidth+2  {data_validity, credits_hdr, credits}.
REQ-010 req_valid_o / req_ready_i / req_data_o  out/in/out  1/1/DataWidth  request-VC flit output to NoC.
REQ-011 rsp_valid_o / rsp_ready_i / rsp_data_o  out/in/out  1/1/DataWidth  response-VC flit output to NoC.
REQ-012 rx_cred_valid_o / rx_cred_hdr_o / rx_cred_o  out  1/1/CredWidth  single-cycle report of credits carried by an accepted packet (for the local transmitter).
REQ-013 cred_ret_valid_o / cred_ret_ready_i / cred_ret_hdr_o / cred_ret_o  out/in/out/out  1/1/1/CredWidth  credit-return offer to the local transmitter.

Function
REQ-014 Two stream FIFOs of depth NumCred, one per VC; data_hdr selects the FIFO.
REQ-015 axis_in_tready_o = (data_validity & selected FIFO not full) | ~data_validity; credit-only packets (data_validity=0) are always accepted and write no FIFO.
REQ-016 On every accepted packet, rx_cred_valid_o pulses the next cycle with credits_hdr and credits, including credits=0.
REQ-017 Per-VC pending counter pend_q increments by 1 on each NoC-side flit handshake of that VC.
REQ-018 FSM states IDLE and OFFER; IDLE→OFFER when max(pend_req, pend_rsp) >= ForceSendThresh.
REQ-019 On IDLE→OFFER, the VC with strictly larger count is selected (tie → response); its count and hdr are latched into cred_ret_o/cred_ret_hdr_o, and that counter becomes (count − latched + same-cycle drain).
REQ-020 In OFFER: cred_ret_valid_o=1, cred_ret_o/cred_ret_hdr_o held stable until cred_ret_ready_i; then →IDLE with cred_ret_valid_o=0 the next cycle.
REQ-021 Minimum offer spacing: one IDLE cycle between consecutive offers.
REQ-022 Counters saturate-free by construction: pend_q + FIFO occupancy + outstanding remote credits never exceeds NumCred; overflow is a design error flagged by assertion.
REQ-023 Latency: AXIS accept to NoC valid = 1 cycle; NoC drain to counter update = 1 cycle.

Reset
REQ-024 On rst_ni low, asynchronously: FIFOs empty, pend counters 0, FSM IDLE, all valid outputs 0, data/credit outputs 0.
REQ-025 Reset mid-OFFER discards the latched offer; no credits are returned for it.

Configuration
REQ-026 Macro NOC_BRIDGE_RX_CRED_TIMEOUT_EN: when defined, a 5-bit idle counter forces IDLE→OFFER when either pend count is nonzero and no offer has occurred for 16 cycles; counter clears on every offer and on reset.
REQ-027 Without NOC_BRIDGE_RX_CRED_TIMEOUT_EN, offers occur only per REQ-018 and the timer is absent.

Verification (NumCred=8, ForceSendThresh=4)
REQ-028 Three request flits in, req_ready_i=1 → three req handshakes, pend_req=3, no offer.
REQ-029 Four request flits drained → offer hdr=request, cred_ret=4; ready held low 5 cycles → values stable, then handshake, pend_req=0.
REQ-030 pend_req=4, pend_rsp=4 simultaneously → offer hdr=response, cred_ret=4; next offer hdr=request, cred_ret=4.
REQ-031 Request FIFO full (8 flits, req_ready_i=0), ninth request packet → tready=0; credit-only packet with credits=3, credits_hdr=response → accepted, rx_cred pulse hdr=1, value 3.
REQ-032 Drain during IDLE→OFFER cycle with pend_rsp=4 → cred_ret=4, pend_rsp=1 afterwards.
REQ-033 With NOC_BRIDGE_RX_CRED_TIMEOUT_EN, pend_req=1 and no traffic → offer cred_ret=1 after 16 cycles; without it → no offer after 100 cycles.
